// File: rtl/video_timing_gen.sv
// Raster timing generator: hcnt/vcnt counters, sync/blank decode and a staged,
// frame-synchronous runtime configuration path with validity checking.
module video_timing_gen #(
    parameter int unsigned HW       = 12,
    parameter int unsigned VW       = 11,
    parameter int unsigned DEF_HA   = 1920,
    parameter int unsigned DEF_HFP  = 88,
    parameter int unsigned DEF_HS   = 44,
    parameter int unsigned DEF_HBP  = 148,
    parameter int unsigned DEF_VA   = 1080,
    parameter int unsigned DEF_VFP  = 4,
    parameter int unsigned DEF_VS   = 5,
    parameter int unsigned DEF_VBP  = 36,
    parameter int unsigned DEF_HPOL = 0,
    parameter int unsigned DEF_VPOL = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          cfg_load,
    input  logic [HW-1:0] cfg_ha,
    input  logic [HW-1:0] cfg_hfp,
    input  logic [HW-1:0] cfg_hs,
    input  logic [HW-1:0] cfg_hbp,
    input  logic [VW-1:0] cfg_va,
    input  logic [VW-1:0] cfg_vfp,
    input  logic [VW-1:0] cfg_vs,
    input  logic [VW-1:0] cfg_vbp,
    input  logic          cfg_hpol,
    input  logic          cfg_vpol,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_n,
    output logic          sof,
    output logic          eol,
    output logic          cfg_pending,
    output logic          cfg_err
);

    localparam int unsigned HXW = HW + 2;
    localparam int unsigned VXW = VW + 2;
    localparam logic [HXW-1:0] H_MAX = HXW'((64'd1 << HW) - 64'd1);
    localparam logic [VXW-1:0] V_MAX = VXW'((64'd1 << VW) - 64'd1);

    typedef struct packed {
        logic [HW-1:0] ha;
        logic [HW-1:0] hfp;
        logic [HW-1:0] hs;
        logic [HW-1:0] hbp;
        logic [VW-1:0] va;
        logic [VW-1:0] vfp;
        logic [VW-1:0] vs;
        logic [VW-1:0] vbp;
        logic          hpol;
        logic          vpol;
    } timing_t;

    // Idle until the first enabled clock presents (0,0); never returns to idle except by reset.
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam timing_t DEF_TIMING = '{
        ha:   HW'(DEF_HA),
        hfp:  HW'(DEF_HFP),
        hs:   HW'(DEF_HS),
        hbp:  HW'(DEF_HBP),
        va:   VW'(DEF_VA),
        vfp:  VW'(DEF_VFP),
        vs:   VW'(DEF_VS),
        vbp:  VW'(DEF_VBP),
        hpol: 1'(DEF_HPOL),
        vpol: 1'(DEF_VPOL)
    };

    function automatic logic [HXW-1:0] h_total(input timing_t t);
        return HXW'(t.ha) + HXW'(t.hfp) + HXW'(t.hs) + HXW'(t.hbp);
    endfunction

    function automatic logic [VXW-1:0] v_total(input timing_t t);
        return VXW'(t.va) + VXW'(t.vfp) + VXW'(t.vs) + VXW'(t.vbp);
    endfunction

    state_t         state_q, state_d;
    timing_t        shadow_q, shadow_d;
    timing_t        staging_q, staging_d;
    timing_t        cfg_in_c;
    logic           pending_d, err_d;
    logic [HW-1:0]  hcnt_d;
    logic [VW-1:0]  vcnt_d;
    logic           wrap_c;
    logic           cfg_valid_c;
    logic           h_end_c, v_end_c;
    logic [HXW-1:0] cfg_ht_c, cur_ht_c, nxt_ht_c;
    logic [VXW-1:0] cfg_vt_c, cur_vt_c;
    logic [HXW-1:0] nh_x_c, hs_start_c, hs_stop_c;
    logic [VXW-1:0] nv_x_c, vs_start_c, vs_stop_c;
    logic           de_d, hsync_d, vsync_d, sof_d, eol_d;

    // Incoming configuration and its legality check.
    always_comb begin
        cfg_in_c = '{
            ha: cfg_ha, hfp: cfg_hfp, hs: cfg_hs, hbp: cfg_hbp,
            va: cfg_va, vfp: cfg_vfp, vs: cfg_vs, vbp: cfg_vbp,
            hpol: cfg_hpol, vpol: cfg_vpol
        };
        cfg_ht_c    = h_total(cfg_in_c);
        cfg_vt_c    = v_total(cfg_in_c);
        cfg_valid_c = (cfg_ha  != '0) && (cfg_hfp != '0) && (cfg_hs  != '0) && (cfg_hbp != '0) &&
                      (cfg_va  != '0) && (cfg_vfp != '0) && (cfg_vs  != '0) && (cfg_vbp != '0) &&
                      (cfg_ht_c <= H_MAX) && (cfg_vt_c <= V_MAX);
    end

    // End-of-line/frame use >= so counters held past a freshly shrunk timing still wrap.
    always_comb begin
        cur_ht_c = h_total(shadow_q);
        cur_vt_c = v_total(shadow_q);
        h_end_c  = HXW'(hcnt) >= (cur_ht_c - HXW'(1));
        v_end_c  = VXW'(vcnt) >= (cur_vt_c - VXW'(1));
    end

    // Next position, state and configuration bookkeeping.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt;
        vcnt_d    = vcnt;
        shadow_d  = shadow_q;
        staging_d = staging_q;
        pending_d = cfg_pending;
        err_d     = cfg_err;
        wrap_c    = 1'b0;

        if (enable) begin
            state_d = ST_RUN;
            if (state_q == ST_IDLE) begin
                hcnt_d = '0;
                vcnt_d = '0;
                wrap_c = 1'b1;
            end else if (h_end_c) begin
                hcnt_d = '0;
                if (v_end_c) begin
                    vcnt_d = '0;
                    wrap_c = 1'b1;
                end else begin
                    vcnt_d = vcnt + VW'(1);
                end
            end else begin
                hcnt_d = hcnt + HW'(1);
            end

            // Wrap consumes the old staging before a coincident load replaces it.
            if (wrap_c && cfg_pending) begin
                shadow_d  = staging_q;
                pending_d = 1'b0;
            end
            if (cfg_load) begin
                if (cfg_valid_c) begin
                    staging_d = cfg_in_c;
                    pending_d = 1'b1;
                    err_d     = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (cfg_load) begin
            if (cfg_valid_c) begin
                shadow_d  = cfg_in_c;
                staging_d = cfg_in_c;
                pending_d = 1'b0;
                err_d     = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Output decode against the position and timing that take effect this edge.
    always_comb begin
        nh_x_c     = HXW'(hcnt_d);
        nv_x_c     = VXW'(vcnt_d);
        nxt_ht_c   = h_total(shadow_d);
        hs_start_c = HXW'(shadow_d.ha) + HXW'(shadow_d.hfp);
        hs_stop_c  = hs_start_c + HXW'(shadow_d.hs);
        vs_start_c = VXW'(shadow_d.va) + VXW'(shadow_d.vfp);
        vs_stop_c  = vs_start_c + VXW'(shadow_d.vs);

        de_d    = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        hsync_d = ~shadow_d.hpol;
        vsync_d = ~shadow_d.vpol;

        if (enable) begin
            de_d  = (nh_x_c < HXW'(shadow_d.ha)) && (nv_x_c < VXW'(shadow_d.va));
            sof_d = (hcnt_d == '0) && (vcnt_d == '0);
            eol_d = nh_x_c == (nxt_ht_c - HXW'(1));
            if ((nh_x_c >= hs_start_c) && (nh_x_c < hs_stop_c)) begin
                hsync_d = shadow_d.hpol;
            end
            if ((nv_x_c >= vs_start_c) && (nv_x_c < vs_stop_c)) begin
                vsync_d = shadow_d.vpol;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shadow_q    <= DEF_TIMING;
            staging_q   <= DEF_TIMING;
            hcnt        <= '0;
            vcnt        <= '0;
            de          <= 1'b0;
            blank_n     <= 1'b0;
            hsync       <= ~DEF_TIMING.hpol;
            vsync       <= ~DEF_TIMING.vpol;
            sof         <= 1'b0;
            eol         <= 1'b0;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            staging_q   <= staging_d;
            hcnt        <= hcnt_d;
            vcnt        <= vcnt_d;
            de          <= de_d;
            blank_n     <= de_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            sof         <= sof_d;
            eol         <= eol_d;
            cfg_pending <= pending_d;
            cfg_err     <= err_d;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: directed timing scenarios plus randomized
// enable/config traffic compared cycle by cycle against a behavioural raster model.
module tb_video_timing_gen;

    localparam int HW = 12;
    localparam int VW = 11;
    localparam int H_LIMIT = (1 << HW) - 1;
    localparam int V_LIMIT = (1 << VW) - 1;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        int hpol, vpol;
    } tcfg_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          cfg_load = 1'b0;
    logic [HW-1:0] cfg_ha, cfg_hfp, cfg_hs, cfg_hbp;
    logic [VW-1:0] cfg_va, cfg_vfp, cfg_vs, cfg_vbp;
    logic          cfg_hpol, cfg_vpol;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          de, hsync, vsync, blank_n, sof, eol, cfg_pending, cfg_err;

    video_timing_gen dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
        .cfg_ha(cfg_ha), .cfg_hfp(cfg_hfp), .cfg_hs(cfg_hs), .cfg_hbp(cfg_hbp),
        .cfg_va(cfg_va), .cfg_vfp(cfg_vfp), .cfg_vs(cfg_vs), .cfg_vbp(cfg_vbp),
        .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol),
        .hcnt(hcnt), .vcnt(vcnt), .de(de), .hsync(hsync), .vsync(vsync),
        .blank_n(blank_n), .sof(sof), .eol(eol),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: raster position plus live/staged timing records.
    tcfg_t def_cfg = '{1920, 88, 44, 148, 1080, 4, 5, 36, 0, 0};
    tcfg_t drv;
    tcfg_t m_sh, m_st;
    bit    m_pend, m_err, m_run, m_en;
    int    m_h, m_v;

    function automatic int ht_of(input tcfg_t c);
        return c.ha + c.hfp + c.hs + c.hbp;
    endfunction

    function automatic int vt_of(input tcfg_t c);
        return c.va + c.vfp + c.vs + c.vbp;
    endfunction

    function automatic bit cfg_ok(input tcfg_t c);
        if (c.ha == 0 || c.hfp == 0 || c.hs == 0 || c.hbp == 0) return 0;
        if (c.va == 0 || c.vfp == 0 || c.vs == 0 || c.vbp == 0) return 0;
        return (ht_of(c) <= H_LIMIT) && (vt_of(c) <= V_LIMIT);
    endfunction

    task automatic model_reset();
        m_sh = def_cfg; m_st = def_cfg;
        m_pend = 0; m_err = 0; m_run = 0; m_en = 0;
        m_h = 0; m_v = 0;
    endtask

    task automatic model_step();
        int ht, vt;
        bit frame_start;
        ht = ht_of(m_sh);
        vt = vt_of(m_sh);
        m_en = enable;
        if (enable) begin
            if (!m_run) begin
                m_h = 0; m_v = 0;
            end else begin
                m_h = m_h + 1;
                if (m_h >= ht) begin
                    m_h = 0;
                    m_v = m_v + 1;
                    if (m_v >= vt) m_v = 0;
                end
            end
            frame_start = (m_h == 0) && (m_v == 0);
            m_run = 1;
            if (frame_start && m_pend) begin
                m_sh = m_st; m_pend = 0;
            end
            if (cfg_load) begin
                if (cfg_ok(drv)) begin m_st = drv; m_pend = 1; m_err = 0; end
                else m_err = 1;
            end
        end else if (cfg_load) begin
            if (cfg_ok(drv)) begin m_sh = drv; m_st = drv; m_pend = 0; m_err = 0; end
            else m_err = 1;
        end
    endtask

    function automatic logic [7:0] exp_flags();
        logic d, hs, vs, s, e;
        int hs0, vs0;
        d = 0; s = 0; e = 0;
        hs = (m_sh.hpol == 0);
        vs = (m_sh.vpol == 0);
        if (m_en) begin
            hs0 = m_sh.ha + m_sh.hfp;
            vs0 = m_sh.va + m_sh.vfp;
            d = (m_h < m_sh.ha) && (m_v < m_sh.va);
            s = (m_h == 0) && (m_v == 0);
            e = (m_h == ht_of(m_sh) - 1);
            if (m_h >= hs0 && m_h < hs0 + m_sh.hs) hs = (m_sh.hpol != 0);
            if (m_v >= vs0 && m_v < vs0 + m_sh.vs) vs = (m_sh.vpol != 0);
        end
        return {d, d, hs, vs, s, e, m_pend, m_err};
    endfunction

    task automatic compare();
        check("hcnt", 32'(hcnt), 32'(m_h));
        check("vcnt", 32'(vcnt), 32'(m_v));
        check("flags{de,blank_n,hs,vs,sof,eol,pend,err}",
              32'({de, blank_n, hsync, vsync, sof, eol, cfg_pending, cfg_err}),
              32'(exp_flags()));
    endtask

    task automatic set_cfg(input tcfg_t c);
        drv = c;
        cfg_ha = HW'(c.ha); cfg_hfp = HW'(c.hfp); cfg_hs = HW'(c.hs); cfg_hbp = HW'(c.hbp);
        cfg_va = VW'(c.va); cfg_vfp = VW'(c.vfp); cfg_vs = VW'(c.vs); cfg_vbp = VW'(c.vbp);
        cfg_hpol = 1'(c.hpol); cfg_vpol = 1'(c.vpol);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        cfg_load = 1'b0;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        reset = 1'b0; enable = 1'b0; cfg_load = 1'b0;
        model_reset();
        #1 compare();
        @(negedge clk);
        compare();
        reset = 1'b1;
    endtask

    task automatic run_until_sof(input int max, output int n, output bit found);
        n = 0; found = 0;
        for (int i = 0; i < max && !found; i++) begin
            tick();
            n = i + 1;
            if (sof) found = 1;
        end
    endtask

    task automatic steer_to(input int h, input int v);
        for (int i = 0; i < 2000 && !(m_h == h && m_v == v); i++) tick();
        check("steer_reached", 32'(m_h == h && m_v == v), 32'd1);
    endtask

    function automatic tcfg_t rand_cfg();
        tcfg_t c;
        c.ha = $urandom_range(1, 20); c.hfp = $urandom_range(1, 4);
        c.hs = $urandom_range(1, 4);  c.hbp = $urandom_range(1, 4);
        c.va = $urandom_range(1, 8);  c.vfp = $urandom_range(1, 3);
        c.vs = $urandom_range(1, 3);  c.vbp = $urandom_range(1, 3);
        c.hpol = $urandom_range(0, 1); c.vpol = $urandom_range(0, 1);
        case ($urandom_range(0, 9))
            0: case ($urandom_range(0, 7))
                   0: c.ha = 0;  1: c.hfp = 0; 2: c.hs = 0;  3: c.hbp = 0;
                   4: c.va = 0;  5: c.vfp = 0; 6: c.vs = 0;  default: c.vbp = 0;
               endcase
            1: c.ha = 4094;
            2: c.va = 2046;
            default: ;
        endcase
        return c;
    endfunction

    tcfg_t small_cfg = '{8, 2, 3, 3, 4, 1, 2, 1, 0, 0};
    tcfg_t cfg_b     = '{6, 1, 2, 1, 3, 1, 1, 1, 1, 1};
    tcfg_t cfg_c     = '{5, 1, 1, 1, 2, 1, 1, 1, 0, 1};

    initial begin
        int de_cnt, hs_first, hs_last, vs_first, vs_last, eol_h, sof_a, sof_b, n, hold;
        bit found;
        tcfg_t bad;

        set_cfg(def_cfg);
        hard_reset();
        check("rst_blank_n", 32'(blank_n), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);

        // Default 1080p timing: first presented pixel and the whole of line 0.
        enable = 1'b1;
        tick();
        check("first_hcnt", 32'(hcnt), 32'd0);
        check("first_sof", 32'(sof), 32'd1);
        check("first_de", 32'(de), 32'd1);
        de_cnt = 0; hs_first = -1; hs_last = -1; eol_h = -1;
        for (int i = 0; i < 2205; i++) begin
            if (vcnt == 0) begin
                if (de) de_cnt++;
                if (!hsync) begin
                    if (hs_first < 0) hs_first = hcnt;
                    hs_last = hcnt;
                end
                if (eol) eol_h = hcnt;
            end
            tick();
        end
        check("def_de_per_line", 32'(de_cnt), 32'd1920);
        check("def_hs_first", 32'(hs_first), 32'd2008);
        check("def_hs_last", 32'(hs_last), 32'd2051);
        check("def_eol_h", 32'(eol_h), 32'd2199);

        // Small timing loaded while stopped takes effect immediately.
        hard_reset();
        set_cfg(small_cfg);
        cfg_load = 1'b1;
        tick();
        check("idle_load_pend", 32'(cfg_pending), 32'd0);
        enable = 1'b1;
        hs_first = -1; hs_last = -1; vs_first = -1; vs_last = -1; sof_a = -1; sof_b = -1;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (vcnt == 0 && !hsync) begin
                if (hs_first < 0) hs_first = hcnt;
                hs_last = hcnt;
            end
            if (!vsync) begin
                if (vs_first < 0) vs_first = vcnt;
                vs_last = vcnt;
            end
            if (eol) check("small_eol_h", 32'(hcnt), 32'd15);
            if (sof) begin
                if (sof_a < 0) sof_a = i; else if (sof_b < 0) sof_b = i;
            end
        end
        check("small_hs_first", 32'(hs_first), 32'd10);
        check("small_hs_last", 32'(hs_last), 32'd12);
        check("small_vs_first", 32'(vs_first), 32'd5);
        check("small_vs_last", 32'(vs_last), 32'd6);
        check("small_frame_len", 32'(sof_b - sof_a), 32'd128);

        // Mid-frame load waits for the frame boundary.
        steer_to(3, 2);
        set_cfg(cfg_b);
        cfg_load = 1'b1;
        tick();
        check("mid_pend_set", 32'(cfg_pending), 32'd1);
        run_until_sof(200, n, found);
        check("mid_sof_found", 32'(found), 32'd1);
        check("mid_ticks_to_wrap", 32'(n), 32'd92);
        check("mid_pend_clr", 32'(cfg_pending), 32'd0);
        run_until_sof(200, n, found);
        check("new_frame_len", 32'(n), 32'd60);

        // Rejected loads: zero sync width and horizontal overflow.
        bad = cfg_b; bad.hs = 0;
        set_cfg(bad);
        cfg_load = 1'b1;
        tick();
        check("err_hs0", 32'(cfg_err), 32'd1);
        check("err_hs0_pend", 32'(cfg_pending), 32'd0);
        bad = cfg_b; bad.ha = 4094;
        set_cfg(bad);
        cfg_load = 1'b1;
        tick();
        check("err_ovf", 32'(cfg_err), 32'd1);
        run_until_sof(200, n, found);
        run_until_sof(200, n, found);
        check("err_frame_len", 32'(n), 32'd60);

        // Load on the wrap cycle: older staging applies, newer stays pending.
        set_cfg(small_cfg);
        cfg_load = 1'b1;
        tick();
        steer_to(9, 5);
        set_cfg(cfg_c);
        cfg_load = 1'b1;
        tick();
        check("wrap_sof", 32'(sof), 32'd1);
        check("wrap_pend", 32'(cfg_pending), 32'd1);
        run_until_sof(300, n, found);
        check("wrap_frame_len", 32'(n), 32'd128);
        run_until_sof(300, n, found);
        check("wrap_next_len", 32'(n), 32'd40);

        // Enable dropped for five clocks mid-line.
        steer_to(5, 1);
        hold = m_h;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz_hcnt", 32'(hcnt), 32'(hold));
            check("frz_de", 32'(de), 32'd0);
        end
        enable = 1'b1;
        tick();
        check("resume_hcnt", 32'(hcnt), 32'(hold + 1));

        // Randomized enable and configuration traffic.
        for (int i = 0; i < 20000; i++) begin
            enable = ($urandom_range(0, 15) != 0);
            set_cfg(rand_cfg());
            cfg_load = ($urandom_range(0, 99) == 0);
            tick();
        end

        // Asynchronous reset mid-frame.
        enable = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 model_reset();
        compare();
        check("arst_hcnt", 32'(hcnt), 32'd0);
        check("arst_de", 32'(de), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_arst_sof", 32'(sof), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter HW, default 12, meaning horizontal counter/config width.
REQ-002 SHALL have parameter VW, default 11, meaning vertical counter/config width.
REQ-003 SHALL have parameters DEF_HA/DEF_HFP/DEF_HS/DEF_HBP, defaults 1920/88/44/148, meaning reset horizontal timing.
REQ-004 SHALL have parameters DEF_VA/DEF_VFP/DEF_VS/DEF_VBP, defaults 1080/4/5/36, meaning reset vertical timing.
REQ-005 SHALL have parameters DEF_HPOL/DEF_VPOL, default 0/0, meaning sync active level (0 = active-low).
REQ-006 SHALL have ports as follows (reset is asynchronous, active-low; clock is clk):
 clk  in  1  pixel clock, rising edge
 reset  in  1  asynchronous active-low reset
 enable  in  1  run counters when high
 cfg_load  in  1  single-cycle request to apply cfg_* at next frame boundary
 cfg_ha/cfg_hfp/cfg_hs/cfg_hbp  in  HW each  horizontal active/front porch/sync/back porch
 cfg_va/cfg_vfp/cfg_vs/cfg_vbp  in  VW each  vertical active/front porch/sync/back porch
 cfg_hpol/cfg_vpol  in  1  sync polarity
 hcnt  out  HW  pixel position in line
 vcnt  out  VW  line position in frame
 de  out  1  active video
 hsync/vsync  out  1  sync, polarity applied
 blank_n  out  1  high outside blanking (equals de)
 sof  out  1  one-cycle pulse at hcnt=0,vcnt=0
 eol  out  1  one-cycle pulse at hcnt=HT-1
 cfg_pending  out  1  accepted config waiting for frame boundary
 cfg_err  out  1  last cfg_load rejected

Function
REQ-007 SHALL define HT=HA+HFP+HS+HBP and VT=VA+VFP+VS+VBP from the active shadow config.
REQ-008 SHALL order the line as active [0,HA-1], front porch [HA,HA+HFP-1], sync [HA+HFP,HA+HFP+HS-1], back porch to HT-1; vertical likewise in lines.
REQ-009 SHALL, when enable=1, increment hcnt each clk; at hcnt=HT-1 wrap hcnt to 0 and increment vcnt; at vcnt=VT-1 with hcnt=HT-1 wrap both to 0.
REQ-010 SHALL, when enable=0, hold hcnt/vcnt, drive de=0, sof=0, eol=0, and hsync/vsync at their inactive level.
REQ-011 SHALL register all outputs so that de, hsync, vsync, sof and eol are cycle-aligned with the hcnt/vcnt value presented the same cycle (zero relative latency).
REQ-012 SHALL assert de iff hcnt<HA and vcnt<VA.
REQ-013 SHALL assert hsync (at level cfg_hpol) iff hcnt is in the horizontal sync window, on every line including vertical blanking.
REQ-014 SHALL assert vsync (at level cfg_vpol) for whole lines vcnt in [VA+VFP,VA+VFP+VS-1], changing only at hcnt=0.
REQ-015 SHALL, on cfg_load, check all eight fields nonzero and HT<=2^HW-1, VT<=2^VW-1 (computed at width HW+2/VW+2); if valid set cfg_pending=1, clear cfg_err, capture fields into a staging register; if invalid set cfg_err=1 and leave staging/pending unchanged.
REQ-016 SHALL copy staging to shadow and clear cfg_pending on the clk where the counter wraps to (0,0); the new frame starts with new timing, no partial frame.
REQ-017 SHALL let a cfg_load while pending overwrite staging (last valid load wins).
REQ-018 SHALL, if cfg_load coincides with the wrap cycle, apply the previous staging and leave the new one pending.
REQ-019 SHALL copy staging to shadow immediately when cfg_load is valid while enable=0.

Reset
REQ-020 SHALL, while reset=0, force hcnt=0, vcnt=0, de=0, blank_n=0, sof=0, eol=0, cfg_pending=0, cfg_err=0, hsync/vsync inactive, and shadow/staging to DEF_* parameters.
REQ-021 SHALL, on first enabled clk after reset release, present hcnt=0,vcnt=0 with sof=1 and de=1.

Verification
REQ-022 Reset then enable with defaults -> HT=2200, VT=1125; de high 1920 clks per line for 1080 lines; hsync low hcnt 2008..2051; sof every 2475000 clks.
REQ-023 Load HA=8,HFP=2,HS=3,HBP=3,VA=4,VFP=1,VS=2,VBP=1 with enable=0 -> HT=16, VT=8; hsync active hcnt 10..12; vsync active vcnt 5..6; eol at hcnt=15.
REQ-024 cfg_load mid-frame -> cfg_pending=1 until wrap; old timing until (0,0); new timing from that cycle.
REQ-025 cfg_load with cfg_hs=0 or HT overflow -> cfg_err=1, cfg_pending unchanged, timing unaffected.
REQ-026 enable dropped for 5 clks mid-line -> counters frozen, de=0; resume at same hcnt; assert reset mid-frame -> all outputs to REQ-020 values asynchronously.
